// File: rtl/fc_sched_pkg.sv
// Shared types for the fully-connected engine scheduler: FSM states,
// requester id and the beat-counter width helper.
package fc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_t;

  typedef logic req_id_t;

  // Counter wide enough to hold the larger of the two job lengths.
  function automatic int cnt_width(input int m, input int n);
    return $clog2(((m > n) ? m : n) + 1);
  endfunction

endpackage

// File: rtl/fc_rr_arbiter.sv
// Two-way round-robin grant: a single requester wins outright, a tie goes
// to the requester that did not own the engine last.
module fc_rr_arbiter
  import fc_sched_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output req_id_t    grant,
  output logic       any_req
);

  assign any_req = |valid;
  assign grant   = (&valid) ? ~last_grant : valid[1];

endmodule

// File: rtl/fc_stream_arbiter.sv
// Shares one FC layer engine between two requester streams; a job is N input
// beats followed by M result beats, and the grant is held for the whole job.
module fc_stream_arbiter
  import fc_sched_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 6,
  parameter int T = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in0_valid,
  output logic                in0_ready,
  input  logic signed [T-1:0] in0_data,
  input  logic                in1_valid,
  output logic                in1_ready,
  input  logic signed [T-1:0] in1_data,
  output logic                out0_valid,
  input  logic                out0_ready,
  output logic                out1_valid,
  input  logic                out1_ready,
  output logic signed [T-1:0] out_data,
  output logic                eng_input_valid,
  input  logic                eng_input_ready,
  output logic signed [T-1:0] eng_input_data,
  input  logic                eng_output_valid,
  output logic                eng_output_ready,
  input  logic signed [T-1:0] eng_output_data,
  output logic                grant,
  output logic                busy
);

  localparam int            CW       = cnt_width(M, N);
  localparam logic [CW-1:0] IN_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(M - 1);

  state_t        state, state_nx;
  req_id_t       grant_q, last_grant, arb_grant;
  logic          any_req;
  logic [CW-1:0] in_cnt, out_cnt;
  logic          in_beat, out_beat;

  fc_rr_arbiter u_arb (
    .valid      ({in1_valid, in0_valid}),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_req    (any_req)
  );

  assign grant    = grant_q;
  assign busy     = (state != IDLE);
  assign in_beat  = (state == LOAD)  && eng_input_valid  && eng_input_ready;
  assign out_beat = (state == DRAIN) && eng_output_valid && eng_output_ready;

  // Routing is purely combinational so handshakes add no latency.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    in0_ready        = 1'b0;
    in1_ready        = 1'b0;
    out0_valid       = 1'b0;
    out1_valid       = 1'b0;
    out_data         = '0;
    eng_input_valid  = 1'b0;
    eng_input_data   = '0;
    eng_output_ready = 1'b0;
    state_nx         = state;
    unique case (state)
      IDLE: begin
        if (any_req) state_nx = LOAD;
      end
      LOAD: begin
        eng_input_valid = grant_q ? in1_valid : in0_valid;
        eng_input_data  = grant_q ? in1_data  : in0_data;
        in0_ready       = !grant_q && eng_input_ready;
        in1_ready       =  grant_q && eng_input_ready;
        if (eng_input_valid && eng_input_ready && (in_cnt == IN_LAST)) state_nx = DRAIN;
      end
      DRAIN: begin
        out_data         = eng_output_data;
        out0_valid       = !grant_q && eng_output_valid;
        out1_valid       =  grant_q && eng_output_valid;
        eng_output_ready = grant_q ? out1_ready : out0_ready;
        if (eng_output_valid && eng_output_ready && (out_cnt == OUT_LAST)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      in_cnt     <= '0;
      out_cnt    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) grant_q <= arb_grant;
      if (in_beat) in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + CW'(1);
      if (out_beat) begin
        out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + CW'(1);
        if (out_cnt == OUT_LAST) last_grant <= grant_q;
      end
    end
  end

endmodule

// File: tb/tb_fc_stream_arbiter.sv
// Randomized bench for fc_stream_arbiter: behavioural sources, engine and
// sinks, with a job-level reference model of ownership and routing.
module tb_fc_stream_arbiter;
  import fc_sched_pkg::*;

  localparam int M = 8;
  localparam int N = 6;
  localparam int T = 16;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_DRAIN = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] in_v = '0;
  logic [1:0] out_r = '0;
  logic [T-1:0] in_d [2] = '{'0, '0};
  logic eng_ir = 1'b0, eng_ov = 1'b0;
  logic [T-1:0] eng_odata = '0;
  wire  [1:0] in_r, out_v;
  wire  [T-1:0] out_data, eng_idata;
  wire  eng_iv, eng_or, grant, busy;

  always #5 clk = ~clk;

  fc_stream_arbiter #(.M(M), .N(N), .T(T)) dut (
    .clk              (clk),
    .reset            (reset),
    .in0_valid        (in_v[0]),
    .in0_ready        (in_r[0]),
    .in0_data         (in_d[0]),
    .in1_valid        (in_v[1]),
    .in1_ready        (in_r[1]),
    .in1_data         (in_d[1]),
    .out0_valid       (out_v[0]),
    .out0_ready       (out_r[0]),
    .out1_valid       (out_v[1]),
    .out1_ready       (out_r[1]),
    .out_data         (out_data),
    .eng_input_valid  (eng_iv),
    .eng_input_ready  (eng_ir),
    .eng_input_data   (eng_idata),
    .eng_output_valid (eng_ov),
    .eng_output_ready (eng_or),
    .eng_output_data  (eng_odata),
    .grant            (grant),
    .busy             (busy)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus knobs and environment state.
  logic [T-1:0] vec [2][N];
  int  idx [2], jobs_left [2], drop_pct [2], sink_mode [2], hold_at [2], hold_cnt [2];
  int  in_beats [2], out_beats [2];
  int  hold_len = 5, eng_in_pct = 100, eng_out_pct = 100;
  bit  seq_words = 0, force_min = 0, seen_min = 0, tog = 0, rst_req = 0, chk_rst = 0, prev_busy = 0;
  logic [T-1:0] res_q [$];
  bit  glog [$];
  int  eng_in_cnt = 0, cyc = 0, first_in_cyc = 0, last_in_cyc = 0;

  // Reference model: who owns the engine and how far the job has progressed.
  int  m_phase = PH_IDLE;
  bit  m_owner = 0, m_last = 1;
  int  m_words = 0;

  task automatic new_vec(input int k);
    for (int i = 0; i < N; i++) vec[k][i] = seq_words ? T'(i + 1) : T'($urandom);
  endtask

  task automatic step();
    logic [7:0] act, exp;
    logic [1:0] e_in_r, e_out_v;
    logic e_eiv, e_eor;
    logic [T-1:0] e_id, e_od;
    @(posedge clk);
    #1;
    cyc++;
    if (chk_rst) begin
      check("rst_state", 32'(dut.state), 32'(IDLE));
      check("rst_in_cnt", 32'(dut.in_cnt), 0);
      check("rst_out_cnt", 32'(dut.out_cnt), 0);
      check("rst_last_grant", 32'(dut.last_grant), 1);
      chk_rst = 0;
    end
    reset = rst_req;
    for (int k = 0; k < 2; k++) begin
      logic v;
      v = (jobs_left[k] > 0) && ($urandom_range(99) >= drop_pct[k]);
      if (jobs_left[k] > 0 && idx[k] == hold_at[k] && hold_cnt[k] < hold_len) begin
        v = 1'b0;
        hold_cnt[k]++;
      end
      in_v[k] = v;
      in_d[k] = vec[k][idx[k]];
      case (sink_mode[k])
        0:       out_r[k] = 1'b1;
        1:       out_r[k] = tog;
        default: out_r[k] = 1'($urandom_range(1));
      endcase
    end
    tog = ~tog;
    eng_ir    = (res_q.size() == 0) && ($urandom_range(99) < eng_in_pct);
    eng_ov    = (res_q.size() != 0) && ($urandom_range(99) < eng_out_pct);
    eng_odata = (res_q.size() != 0) ? res_q[0] : '0;
    #1;

    e_in_r = '0; e_out_v = '0; e_eiv = 1'b0; e_eor = 1'b0; e_id = '0; e_od = '0;
    if (m_phase == PH_LOAD) begin
      e_in_r[m_owner] = eng_ir;
      e_eiv = in_v[m_owner];
      e_id  = in_d[m_owner];
    end
    if (m_phase == PH_DRAIN) begin
      e_out_v[m_owner] = eng_ov;
      e_eor = out_r[m_owner];
      e_od  = eng_odata;
    end
    act = {busy, busy & grant, in_r[0], in_r[1], out_v[0], out_v[1], eng_iv, eng_or};
    exp = {(m_phase != PH_IDLE), (m_phase != PH_IDLE) & m_owner, e_in_r[0], e_in_r[1],
           e_out_v[0], e_out_v[1], e_eiv, e_eor};
    check("ctl", 32'(act), 32'(exp));
    check("eng_in_data", 32'(eng_idata), 32'(e_id));
    check("out_data", 32'(out_data), 32'(e_od));
    if (busy && !prev_busy) glog.push_back(grant);
    prev_busy = busy;

    if (reset) begin
      m_phase = PH_IDLE; m_owner = 0; m_last = 1; m_words = 0;
      res_q.delete();
      eng_in_cnt = 0;
      idx[0] = 0; idx[1] = 0;
      chk_rst = 1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (in_v[k] && in_r[k]) begin
          in_beats[k]++;
          idx[k]++;
          if (idx[k] == N) begin
            idx[k] = 0;
            jobs_left[k]--;
            new_vec(k);
          end
        end
        if (out_v[k] && out_r[k]) begin
          out_beats[k]++;
          if (out_data == 16'h8000) seen_min = 1;
        end
      end
      if (eng_iv && eng_ir) begin
        if (eng_in_cnt == 0) first_in_cyc = cyc;
        last_in_cyc = cyc;
        eng_in_cnt++;
        if (eng_in_cnt == N) begin
          eng_in_cnt = 0;
          for (int j = 0; j < M; j++)
            res_q.push_back((force_min && j == 0) ? 16'h8000 : T'($urandom));
        end
      end
      if (eng_ov && eng_or) void'(res_q.pop_front());

      case (m_phase)
        PH_IDLE: if (in_v[0] || in_v[1]) begin
          m_owner = (in_v[0] && in_v[1]) ? !m_last : in_v[1];
          m_phase = PH_LOAD;
        end
        PH_LOAD: if (in_v[m_owner] && eng_ir) begin
          m_words++;
          if (m_words == N) begin m_words = 0; m_phase = PH_DRAIN; end
        end
        default: if (eng_ov && out_r[m_owner]) begin
          m_words++;
          if (m_words == M) begin m_words = 0; m_last = m_owner; m_phase = PH_IDLE; end
        end
      endcase
    end
  endtask

  // Reset the DUT and environment, then load a fresh set of jobs.
  task automatic setup(input int j0, input int j1);
    jobs_left[0] = j0; jobs_left[1] = j1;
    new_vec(0); new_vec(1);
    rst_req = 1;
    step();
    rst_req = 0;
    for (int k = 0; k < 2; k++) begin
      in_beats[k] = 0; out_beats[k] = 0; hold_cnt[k] = 0;
    end
    glog.delete();
    seen_min = 0;
  endtask

  task automatic defaults();
    for (int k = 0; k < 2; k++) begin
      drop_pct[k] = 0; sink_mode[k] = 0; hold_at[k] = -1;
    end
    eng_in_pct = 100; eng_out_pct = 100; seq_words = 0; force_min = 0;
  endtask

  task automatic run_until(input int budget, input string tag);
    bit done = 0;
    for (int n = 0; n < budget; n++) begin
      if (jobs_left[0] == 0 && jobs_left[1] == 0 && m_phase == PH_IDLE) begin
        done = 1;
        break;
      end
      step();
    end
    check({tag, "_done"}, 32'(done), 1);
  endtask

  initial begin
    bit exp_order [3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin idx[k] = 0; jobs_left[k] = 0; end
    defaults();
    new_vec(0); new_vec(1);
    rst_req = 1;
    step();
    step();
    rst_req = 0;
    step();
    step();

    // Single requester, words 1..N, engine and sink always ready.
    seq_words = 1;
    setup(1, 0);
    run_until(200, "s1");
    check("s1_consec_in", 32'(last_in_cyc - first_in_cyc), N - 1);
    check("s1_in_beats", 32'(in_beats[0]), N);
    check("s1_out0_beats", 32'(out_beats[0]), M);
    check("s1_out1_beats", 32'(out_beats[1]), 0);

    // Both requesting from reset: round-robin order 0,1,0.
    defaults();
    setup(2, 1);
    run_until(300, "s2");
    check("s2_jobs", 32'(glog.size()), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("s2_grant%0d", i), (i < glog.size()) ? 32'(glog[i]) : 32'd2, 32'(exp_order[i]));

    // in0 stalls after 3 words while in1 waits.
    defaults();
    hold_at[0] = 3;
    setup(1, 1);
    run_until(300, "s3");
    check("s3_stalled", 32'(hold_cnt[0]), hold_len);
    check("s3_in0_beats", 32'(in_beats[0]), N);
    check("s3_in1_beats", 32'(in_beats[1]), N);
    check("s3_out0_beats", 32'(out_beats[0]), M);

    // out1 sink toggles ready every cycle.
    defaults();
    sink_mode[1] = 1;
    setup(0, 1);
    run_until(300, "s4");
    check("s4_out1_beats", 32'(out_beats[1]), M);

    // Most-negative result passes through bit-exact.
    defaults();
    force_min = 1;
    setup(1, 0);
    run_until(300, "s5");
    check("s5_min_seen", 32'(seen_min), 1);

    // Reset in the middle of DRAIN, then a full in1 job.
    defaults();
    setup(1, 0);
    for (int n = 0; n < 100 && out_beats[0] < 4; n++) step();
    check("s6_mid_drain", 32'(out_beats[0]), 4);
    jobs_left[0] = 0;
    rst_req = 1;
    step();
    rst_req = 0;
    jobs_left[1] = 1;
    new_vec(1);
    run_until(300, "s6");
    check("s6_in1_beats", 32'(in_beats[1]), N);
    check("s6_out1_beats", 32'(out_beats[1]), M);

    // Random traffic on every handshake.
    defaults();
    drop_pct[0] = 20; drop_pct[1] = 25;
    sink_mode[0] = 2; sink_mode[1] = 2;
    eng_in_pct = 60; eng_out_pct = 60;
    setup(5, 5);
    run_until(4000, "s7");
    check("s7_in0_beats", 32'(in_beats[0]), 5 * N);
    check("s7_in1_beats", 32'(in_beats[1]), 5 * N);
    check("s7_out0_beats", 32'(out_beats[0]), 5 * M);
    check("s7_out1_beats", 32'(out_beats[1]), 5 * M);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
